// File: rtl/spatz_pkg.sv
// Shared VRF definitions for the Spatz vector register file slice.
// Provides the default word geometry, the word/address/byte-enable types and
// the write-buffer state encoding used by the unit-port responder.
package spatz_pkg;

  localparam int unsigned NRVREG           = 32;
  localparam int unsigned NrWordsPerVector = 2;
  localparam int unsigned VRFWordWidth     = 64;
  localparam int unsigned NrVRFWords       = NRVREG * NrWordsPerVector;

  typedef logic [$clog2(NrVRFWords)-1:0] vrf_addr_t;
  typedef logic [VRFWordWidth-1:0]       vrf_data_t;
  typedef logic [VRFWordWidth/8-1:0]     vrf_be_t;

  typedef enum logic {
    WB_EMPTY = 1'b0,
    WB_FULL  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/spatz_vrf_byte_merge.sv
// Combinational per-byte merge: byte b of merged_o comes from overlay_i when
// be_i[b] is set, otherwise from base_i.
// Ports: base_i / overlay_i (DataWidth), be_i (DataWidth/8), merged_o (DataWidth).
module spatz_vrf_byte_merge #(
  parameter int unsigned DataWidth = 64
) (
  input  logic [DataWidth-1:0]   base_i,
  input  logic [DataWidth-1:0]   overlay_i,
  input  logic [DataWidth/8-1:0] be_i,
  output logic [DataWidth-1:0]   merged_o
);

  always_comb begin
    merged_o = base_i;
    for (int unsigned b = 0; b < DataWidth / 8; b++) begin
      if (be_i[b]) merged_o[b*8 +: 8] = overlay_i[b*8 +: 8];
    end
  end

endmodule

// File: rtl/spatz_vrf_unit_port.sv
// VRF-side responder for one functional unit's read/write port.
// Holds the word storage, a one-entry write buffer (drained into the array
// when bank arbitration allows) and byte-merged read forwarding from it.
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   waddr_i/wdata_i/wbe_i/we_i   write request; wvalid_o acknowledges it
//   raddr_i/re_i                 read request; rdata_o/rvalid_o respond (0 latency)
//   wstall_i / rstall_i          arbitration stalls for buffer drain / read
//   idle_o                       write buffer empty
module spatz_vrf_unit_port
  import spatz_pkg::*;
#(
  parameter  int unsigned NrWords   = NRVREG * NrWordsPerVector,
  parameter  int unsigned DataWidth = VRFWordWidth,
  localparam int unsigned AddrWidth = $clog2(NrWords)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [AddrWidth-1:0]   waddr_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [DataWidth/8-1:0] wbe_i,
  input  logic                   we_i,
  output logic                   wvalid_o,
  input  logic [AddrWidth-1:0]   raddr_i,
  input  logic                   re_i,
  output logic [DataWidth-1:0]   rdata_o,
  output logic                   rvalid_o,
  input  logic                   wstall_i,
  input  logic                   rstall_i,
  output logic                   idle_o
);

  typedef struct packed {
    logic [AddrWidth-1:0]   addr;
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] be;
  } wbuf_t;

  wb_state_e              state_q, state_d;
  wbuf_t                  buf_q, buf_d;
  logic [DataWidth-1:0]   mem_q [NrWords];

  logic                   drain, accept;
  logic [DataWidth-1:0]   drain_word;
  logic [DataWidth/8-1:0] fwd_be;

  assign drain    = (state_q == WB_FULL) && !wstall_i;
  assign accept   = we_i && ((state_q == WB_EMPTY) || drain);
  assign wvalid_o = accept;
  assign idle_o   = (state_q == WB_EMPTY);
  assign rvalid_o = re_i && !rstall_i;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    if (accept) begin
      state_d = WB_FULL;
      buf_d   = '{addr: waddr_i, data: wdata_i, be: wbe_i};
    end else if (drain) begin
      state_d = WB_EMPTY;
    end
  end

  // Drain path: buffered bytes overlaid on the currently stored word.
  spatz_vrf_byte_merge #(
    .DataWidth (DataWidth)
  ) i_drain_merge (
    .base_i    (mem_q[buf_q.addr]),
    .overlay_i (buf_q.data),
    .be_i      (buf_q.be),
    .merged_o  (drain_word)
  );

  // Forwarding uses the start-of-cycle buffer, so a same-cycle write is not
  // visible and a same-cycle drain yields the same bytes as the array later.
  assign fwd_be = ((state_q == WB_FULL) && (buf_q.addr == raddr_i)) ? buf_q.be : '0;

  spatz_vrf_byte_merge #(
    .DataWidth (DataWidth)
  ) i_fwd_merge (
    .base_i    (mem_q[raddr_i]),
    .overlay_i (buf_q.data),
    .be_i      (fwd_be),
    .merged_o  (rdata_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= WB_EMPTY;
      buf_q   <= '0;
      for (int unsigned i = 0; i < NrWords; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      if (drain) mem_q[buf_q.addr] <= drain_word;
    end
  end

endmodule

// File: tb/tb_spatz_vrf_unit_port.sv
module tb_spatz_vrf_unit_port;

  localparam int AW = 6;
  localparam int DW = 64;
  localparam int BW = 8;
  localparam int NW = 64;

  logic          clk = 0;
  logic          rst;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] wdata;
  logic [BW-1:0] wbe;
  logic          we, re, wstall, rstall;
  logic          wvalid_o, rvalid_o, idle_o;
  logic [DW-1:0] rdata_o;

  always #5 clk = ~clk;

  spatz_vrf_unit_port dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .waddr_i  (waddr),
    .wdata_i  (wdata),
    .wbe_i    (wbe),
    .we_i     (we),
    .wvalid_o (wvalid_o),
    .raddr_i  (raddr),
    .re_i     (re),
    .rdata_o  (rdata_o),
    .rvalid_o (rvalid_o),
    .wstall_i (wstall),
    .rstall_i (rstall),
    .idle_o   (idle_o)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: storage array plus a list of writes not yet committed.
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
  } wr_t;

  logic [DW-1:0] ref_mem [NW];
  wr_t           pend[$];

  function automatic logic [DW-1:0] overlay(input logic [DW-1:0] base, input logic [DW-1:0] ov,
                                            input logic [BW-1:0] be);
    logic [DW-1:0] w = base;
    for (int b = 0; b < BW; b++) if (be[b]) w[b*8 +: 8] = ov[b*8 +: 8];
    return w;
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    logic [DW-1:0] w = ref_mem[a];
    if (pend.size() != 0 && pend[0].addr == a) w = overlay(w, pend[0].data, pend[0].be);
    return w;
  endfunction

  task automatic ref_reset();
    for (int i = 0; i < NW; i++) ref_mem[i] = '0;
    pend.delete();
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] wbe;
    logic          re;
    logic [AW-1:0] raddr;
    logic          wstall;
    logic          rstall;
    logic          ewv, erv, eidle, chkrd;
    logic [DW-1:0] erd;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input logic [BW-1:0] be, input logic r, input logic [AW-1:0] ra,
                              input logic ws, input logic rs, input logic ewv, input logic erv,
                              input logic eidle, input logic chkrd, input logic [DW-1:0] erd);
    vec_t v;
    v.we = w; v.waddr = wa; v.wdata = wd; v.wbe = be; v.re = r; v.raddr = ra;
    v.wstall = ws; v.rstall = rs; v.ewv = ewv; v.erv = erv; v.eidle = eidle;
    v.chkrd = chkrd; v.erd = erd;
    return v;
  endfunction

  // One cycle: drive at posedge+1, check at negedge (model and optional
  // constant expectations), advance the model at the posedge.
  task automatic apply(input vec_t v, input bit use_tbl, input string tag);
    logic          m_wv, m_full;
    we = v.we; waddr = v.waddr; wdata = v.wdata; wbe = v.wbe;
    re = v.re; raddr = v.raddr; wstall = v.wstall; rstall = v.rstall;
    @(negedge clk);
    m_full = (pend.size() != 0);
    m_wv   = v.we && (!m_full || !v.wstall);
    chk({tag, " wvalid"}, 64'(wvalid_o), 64'(m_wv));
    chk({tag, " rvalid"}, 64'(rvalid_o), 64'(v.re && !v.rstall));
    chk({tag, " idle"}, 64'(idle_o), 64'(!m_full));
    if (v.re && !v.rstall) chk({tag, " rdata"}, rdata_o, ref_read(v.raddr));
    if (use_tbl) begin
      chk({tag, " tbl_wvalid"}, 64'(wvalid_o), 64'(v.ewv));
      chk({tag, " tbl_rvalid"}, 64'(rvalid_o), 64'(v.erv));
      chk({tag, " tbl_idle"}, 64'(idle_o), 64'(v.eidle));
      if (v.chkrd) chk({tag, " tbl_rdata"}, rdata_o, v.erd);
    end
    @(posedge clk);
    if (m_full && !v.wstall) begin
      ref_mem[pend[0].addr] = overlay(ref_mem[pend[0].addr], pend[0].data, pend[0].be);
      void'(pend.pop_front());
    end
    if (m_wv) begin
      wr_t w;
      w.addr = v.waddr; w.data = v.wdata; w.be = v.wbe;
      pend.push_back(w);
    end
    #1;
  endtask

  localparam logic [DW-1:0] D1  = 64'h0123_4567_89AB_AABB;
  localparam logic [DW-1:0] D2  = 64'h2222_0000_DEAD_0002;
  localparam logic [DW-1:0] D3  = 64'h3333_0000_BEEF_0003;
  localparam logic [DW-1:0] A22 = 64'h2222_2222_2222_2222;
  localparam logic [DW-1:0] P11 = 64'h3333_3333_1111_1111;
  localparam logic [DW-1:0] M7  = 64'h2222_2222_1111_1111;
  localparam logic [DW-1:0] DA  = 64'hA9A9_0000_0000_0009;
  localparam logic [DW-1:0] DB  = 64'hB9B9_1234_5678_0009;
  localparam logic [DW-1:0] FF  = 64'hFFFF_FFFF_FFFF_FFFF;

  vec_t vecs[$];
  vec_t v;

  initial begin
    rst = 1; we = 0; re = 0; waddr = '0; raddr = '0; wdata = '0; wbe = '0;
    wstall = 0; rstall = 0;
    ref_reset();
    #2;
    chk("reset idle", 64'(idle_o), 64'd1);
    chk("reset rdata", rdata_o, 64'd0);
    we = 1; re = 1; #1;
    chk("reset wvalid follows we", 64'(wvalid_o), 64'd1);
    chk("reset rvalid", 64'(rvalid_o), 64'd1);
    we = 0; re = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    //           we wa  wdata wbe    re ra ws rs  wv rv idl crd erd
    vecs.push_back(mk(1, 5, D1,  8'hFF, 1, 5, 0, 0, 1, 1, 1, 1, 64'd0)); // same-cycle: old
    vecs.push_back(mk(0, 0, 0,   8'h00, 1, 5, 0, 0, 0, 1, 0, 1, D1));    // forwarded
    vecs.push_back(mk(0, 0, 0,   8'h00, 1, 5, 0, 0, 0, 1, 1, 1, D1));    // from array
    vecs.push_back(mk(1, 2, D2,  8'hFF, 0, 0, 1, 0, 1, 0, 1, 0, 64'd0));
    vecs.push_back(mk(1, 3, D3,  8'hFF, 0, 0, 1, 0, 0, 0, 0, 0, 64'd0));
    vecs.push_back(mk(1, 3, D3,  8'hFF, 0, 0, 1, 0, 0, 0, 0, 0, 64'd0));
    vecs.push_back(mk(1, 3, D3,  8'hFF, 0, 0, 1, 0, 0, 0, 0, 0, 64'd0));
    vecs.push_back(mk(1, 3, D3,  8'hFF, 1, 2, 0, 0, 1, 1, 0, 1, D2));    // drain+accept
    vecs.push_back(mk(0, 0, 0,   8'h00, 1, 3, 0, 0, 0, 1, 0, 1, D3));
    vecs.push_back(mk(0, 0, 0,   8'h00, 1, 2, 0, 0, 0, 1, 1, 1, D2));
    vecs.push_back(mk(1, 7, A22, 8'hFF, 0, 0, 0, 0, 1, 0, 1, 0, 64'd0));
    vecs.push_back(mk(1, 7, P11, 8'h0F, 0, 0, 0, 0, 1, 0, 0, 0, 64'd0));
    vecs.push_back(mk(0, 0, 0,   8'h00, 1, 7, 1, 0, 0, 1, 0, 1, M7));    // partial forward
    vecs.push_back(mk(0, 0, 0,   8'h00, 1, 7, 0, 0, 0, 1, 0, 1, M7));    // during drain
    vecs.push_back(mk(0, 0, 0,   8'h00, 1, 7, 0, 0, 0, 1, 1, 1, M7));
    vecs.push_back(mk(1, 9, DA,  8'hFF, 0, 0, 0, 0, 1, 0, 1, 0, 64'd0));
    vecs.push_back(mk(0, 0, 0,   8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 64'd0));
    vecs.push_back(mk(1, 9, DB,  8'hFF, 1, 9, 0, 0, 1, 1, 1, 1, DA));    // pre-write data
    vecs.push_back(mk(0, 0, 0,   8'h00, 1, 9, 0, 1, 0, 0, 0, 0, 64'd0)); // rstall
    vecs.push_back(mk(0, 0, 0,   8'h00, 1, 9, 0, 0, 0, 1, 1, 1, DB));
    vecs.push_back(mk(1, 9, FF,  8'h00, 0, 0, 0, 0, 1, 0, 1, 0, 64'd0)); // be == 0
    vecs.push_back(mk(0, 0, 0,   8'h00, 1, 9, 0, 0, 0, 1, 0, 1, DB));
    vecs.push_back(mk(0, 0, 0,   8'h00, 1, 9, 0, 0, 0, 1, 1, 1, DB));
    vecs.push_back(mk(1, 4, D1,  8'hFF, 0, 0, 1, 0, 1, 0, 1, 0, 64'd0));
    vecs.push_back(mk(0, 0, 0,   8'h00, 1, 4, 1, 0, 0, 1, 0, 1, D1));    // buffered addr 4

    foreach (vecs[i]) apply(vecs[i], 1'b1, $sformatf("vec%0d", i));

    // Reset while the buffer holds addr 4: the write must be discarded.
    wstall = 1; re = 1; raddr = 4; we = 0;
    rst = 1;
    #2;
    chk("midrst idle", 64'(idle_o), 64'd1);
    chk("midrst rdata", rdata_o, 64'd0);
    @(posedge clk);
    #1 rst = 0;
    ref_reset();
    v = mk(0, 0, 0, 8'h00, 1, 4, 0, 0, 0, 1, 1, 1, 64'd0);
    apply(v, 1'b1, "post_rst addr4");
    v = mk(0, 0, 0, 8'h00, 1, 2, 0, 0, 0, 1, 1, 1, 64'd0);
    apply(v, 1'b1, "post_rst addr2");

    // Random traffic on a small address window to force collisions.
    for (int n = 0; n < 400; n++) begin
      v.we     = ($urandom_range(0, 99) < 60);
      v.waddr  = AW'($urandom_range(0, 7));
      v.wdata  = {$urandom(), $urandom()};
      v.wbe    = BW'($urandom());
      v.re     = ($urandom_range(0, 99) < 70);
      v.raddr  = AW'($urandom_range(0, 7));
      v.wstall = ($urandom_range(0, 99) < 30);
      v.rstall = ($urandom_range(0, 99) < 20);
      apply(v, 1'b0, $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
